// File: rtl/bus_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_sram_slave_pkg
// Brief  : Shared state encoding and field widths for the burst-bus SRAM slave.
// Rev    : 1.0
// ============================================================================
package bus_sram_slave_pkg;

  localparam int WORD_INDEX_BITS = 9;
  localparam int WINDOW_LSB      = 11;
  localparam int BURST_BITS      = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_ADDR = 3'd1,
    S_READ      = 3'd2,
    S_READ_END  = 3'd3,
    S_WRITE     = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_sram_be_ram.sv
`default_nettype none
// ============================================================================
// Module : bus_sram_be_ram
// Brief  : Single-port synchronous RAM with byte write enables, 1-cycle read,
//          old data returned on read-during-write.
// Rev    : 1.0
// ============================================================================
module bus_sram_be_ram #(
  parameter int DEPTH     = 512,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           byte_we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/bus_sram_slave.sv
`default_nettype none
// ============================================================================
// Module : bus_sram_slave
// Brief  : Burst-bus slave mapping a 512x32 SRAM into a 2 KB window.
//          Optional write stall generation: BUS_SRAM_SLAVE_BUSY_EN.
// Rev    : 1.0
// ============================================================================
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'h5000_0000,
  parameter int          NR_OF_ENTRIES = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  readNotWriteIn,
  input  logic                  dataValidIn,
  input  logic [31:0]           addressDataIn,
  input  logic [3:0]            byteEnablesIn,
  input  logic [BURST_BITS-1:0] burstSizeIn,
  output logic                  dataValidOut,
  output logic [31:0]           addressDataOut,
  output logic                  endTransactionOut,
  output logic                  busErrorOut,
  output logic                  busyOut
);

  state_t                     r_state, w_state_next;
  logic [WORD_INDEX_BITS-1:0] r_index;
  logic [WORD_INDEX_BITS-1:0] r_count;
  logic [BURST_BITS-1:0]      r_burst;
  logic [3:0]                 r_be;
  logic                       r_rnw;
  logic                       r_bus_error, w_error_next;
  logic                       w_hit, w_in_range, w_in_burst;
  logic                       w_busy, w_beat_take, w_beat_write;
  logic [WORD_INDEX_BITS-1:0] w_start_index;
  logic [WORD_INDEX_BITS:0]   w_end_sum;
  logic [3:0]                 w_ram_we;
  logic [31:0]                w_ram_rdata;

  assign w_hit = beginTransactionIn &
                 (addressDataIn[31:WINDOW_LSB] == BASE_ADDRESS[31:WINDOW_LSB]);
  assign w_start_index = addressDataIn[WINDOW_LSB-1:2];
  // Sum cannot exceed 511+255, so bit 9 alone flags an overrun of the array.
  assign w_end_sum  = {1'b0, w_start_index} + {2'b00, burstSizeIn};
  assign w_in_range = ~w_end_sum[WORD_INDEX_BITS];
  assign w_in_burst = (r_count <= {1'b0, r_burst});

  assign w_beat_take  = (r_state == S_WRITE) & dataValidIn & ~w_busy;
  assign w_beat_write = w_beat_take & w_in_burst;
  assign w_ram_we     = (w_beat_write & ~reset) ? r_be : 4'b0000;

`ifdef BUS_SRAM_SLAVE_BUSY_EN
  logic r_busy;
  always_ff @(posedge clock) begin
    if (reset) r_busy <= 1'b0;
    else       r_busy <= w_beat_take;
  end
  assign w_busy = r_busy;
`else
  assign w_busy = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_error_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          if (!w_in_range) begin
            w_state_next = S_ERROR;
            w_error_next = 1'b1;
          end else begin
            w_state_next = readNotWriteIn ? S_READ_ADDR : S_WRITE;
          end
        end
      end
      S_READ_ADDR: w_state_next = S_READ;
      S_READ:      if (r_count == {1'b0, r_burst}) w_state_next = S_READ_END;
      S_READ_END:  w_state_next = S_IDLE;
      S_WRITE: begin
        if (w_beat_take && !w_in_burst) w_error_next = 1'b1;
        if (endTransactionIn) w_state_next = S_IDLE;
      end
      S_ERROR: begin
        if (r_rnw)                 w_state_next = S_READ_END;
        else if (endTransactionIn) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_count     <= '0;
      r_burst     <= '0;
      r_be        <= '0;
      r_rnw       <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bus_error <= w_error_next;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_index <= w_start_index;
            r_count <= '0;
            r_burst <= burstSizeIn;
            r_be    <= byteEnablesIn;
            r_rnw   <= readNotWriteIn;
          end
        end
        // Address runs one word ahead of the data because of RAM latency.
        S_READ_ADDR: r_index <= r_index + 9'd1;
        S_READ: begin
          r_index <= r_index + 9'd1;
          r_count <= r_count + 9'd1;
        end
        S_WRITE: begin
          if (w_beat_write) begin
            r_index <= r_index + 9'd1;
            r_count <= r_count + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  bus_sram_be_ram #(
    .DEPTH     (NR_OF_ENTRIES),
    .ADDR_BITS (WORD_INDEX_BITS)
  ) u_ram (
    .clk     (clock),
    .addr    (r_index),
    .byte_we (w_ram_we),
    .wdata   (addressDataIn),
    .rdata   (w_ram_rdata)
  );

  assign dataValidOut      = (r_state == S_READ);
  assign addressDataOut    = dataValidOut ? w_ram_rdata : 32'h0;
  assign endTransactionOut = (r_state == S_READ_END);
  assign busErrorOut       = r_bus_error;
  assign busyOut           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_sram_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_sram_slave
// Brief  : Directed self-checking bench for bus_sram_slave.
// Rev    : 1.0
// ============================================================================
module tb_bus_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        readNotWriteIn = 1'b0;
  logic        dataValidIn = 1'b0;
  logic [31:0] addressDataIn = 32'h0;
  logic [3:0]  byteEnablesIn = 4'h0;
  logic [7:0]  burstSizeIn = 8'h0;
  logic        dataValidOut;
  logic [31:0] addressDataOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] wdat [16];
  logic [31:0] rexp [16];

  bus_sram_slave dut (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .readNotWriteIn     (readNotWriteIn),
    .dataValidIn        (dataValidIn),
    .addressDataIn      (addressDataIn),
    .byteEnablesIn      (byteEnablesIn),
    .burstSizeIn        (burstSizeIn),
    .dataValidOut       (dataValidOut),
    .addressDataOut     (addressDataOut),
    .endTransactionOut  (endTransactionOut),
    .busErrorOut        (busErrorOut),
    .busyOut            (busyOut)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    readNotWriteIn     = 1'b0;
    dataValidIn        = 1'b0;
    addressDataIn      = 32'h0;
    byteEnablesIn      = 4'h0;
    burstSizeIn        = 8'h0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_dv"},   {31'b0, dataValidOut},      32'd0);
    chk({tag, "_data"}, addressDataOut,             32'd0);
    chk({tag, "_end"},  {31'b0, endTransactionOut}, 32'd0);
    chk({tag, "_err"},  {31'b0, busErrorOut},       32'd0);
  endtask

  // Beats come from wdat[]; a beat is held while the slave stalls.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                          input logic [7:0] burst, input int nbeats);
    logic was_busy;
    int   guard;
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b0;
    addressDataIn      = addr;
    byteEnablesIn      = be;
    burstSizeIn        = burst;
    tick();
    idle_inputs();
    for (int i = 0; i < nbeats; i++) begin
      guard = 0;
      do begin
        was_busy         = busyOut;
        dataValidIn      = 1'b1;
        addressDataIn    = wdat[i];
        endTransactionIn = (i == nbeats - 1) && !was_busy;
        tick();
        guard++;
      end while (was_busy && guard < 4);
      chk("write_busy_release", {31'b0, was_busy}, 32'd0);
    end
    idle_inputs();
  endtask

  // Expected beats come from rexp[].
  task automatic do_read(input logic [31:0] addr, input int burst, input string tag);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b1;
    addressDataIn      = addr;
    burstSizeIn        = 8'(burst);
    byteEnablesIn      = 4'h0;
    tick();
    idle_inputs();
    chk({tag, "_t1_dv"}, {31'b0, dataValidOut}, 32'd0);
    tick();
    for (int k = 0; k <= burst; k++) begin
      chk({tag, "_beat_dv"},   {31'b0, dataValidOut}, 32'd1);
      chk({tag, "_beat_data"}, addressDataOut,        rexp[k]);
      tick();
    end
    chk({tag, "_end"},    {31'b0, endTransactionOut}, 32'd1);
    chk({tag, "_end_dv"}, {31'b0, dataValidOut},      32'd0);
    tick();
    chk({tag, "_end_drop"}, {31'b0, endTransactionOut}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_busy", {31'b0, busyOut}, 32'd0);
    reset = 1'b0;
    tick();

    // Single write then read
    wdat[0] = 32'hDEADBEEF;
    do_write(32'h5000_0010, 4'hF, 8'd0, 1);
    rexp[0] = 32'hDEADBEEF;
    do_read(32'h5000_0010, 0, "single");

    // Burst read of preloaded words 0..7
    for (int i = 0; i < 8; i++) wdat[i] = 32'(i);
    do_write(32'h5000_0000, 4'hF, 8'd7, 8);
    for (int i = 0; i < 8; i++) rexp[i] = 32'(i);
    do_read(32'h5000_0000, 7, "burst8");

    // Byte-masked write
    wdat[0] = 32'h11223344;
    do_write(32'h5000_0020, 4'hF, 8'd0, 1);
    wdat[0] = 32'hAABBCCDD;
    do_write(32'h5000_0020, 4'b0101, 8'd0, 1);
    rexp[0] = 32'h11BB33DD;
    do_read(32'h5000_0020, 0, "bytemask");

    // Last word of the window, in range with burst 0
    wdat[0] = 32'hCAFEF00D;
    do_write(32'h5000_07FC, 4'hF, 8'd0, 1);
    rexp[0] = 32'hCAFEF00D;
    do_read(32'h5000_07FC, 0, "lastword");

    // Read range error
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b1;
    addressDataIn      = 32'h5000_07FC;
    burstSizeIn        = 8'd1;
    tick();
    idle_inputs();
    chk("rderr_t1_err", {31'b0, busErrorOut},       32'd1);
    chk("rderr_t1_end", {31'b0, endTransactionOut}, 32'd0);
    chk("rderr_t1_dv",  {31'b0, dataValidOut},      32'd0);
    tick();
    chk("rderr_t2_end", {31'b0, endTransactionOut}, 32'd1);
    chk("rderr_t2_err", {31'b0, busErrorOut},       32'd0);
    chk("rderr_t2_dv",  {31'b0, dataValidOut},      32'd0);
    tick();
    chk_quiet("rderr_t3");

    // Write range error: beats discarded, word 511 keeps its value
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b0;
    addressDataIn      = 32'h5000_07FC;
    byteEnablesIn      = 4'hF;
    burstSizeIn        = 8'd1;
    tick();
    idle_inputs();
    chk("wrerr_t1_err", {31'b0, busErrorOut}, 32'd1);
    dataValidIn   = 1'b1;
    addressDataIn = 32'h0BAD_0BAD;
    tick();
    chk("wrerr_t2_err", {31'b0, busErrorOut}, 32'd0);
    endTransactionIn = 1'b1;
    tick();
    idle_inputs();
    tick();
    rexp[0] = 32'hCAFEF00D;
    do_read(32'h5000_07FC, 0, "wrerr_keep");

    // Window miss: read and write leave the bus quiet
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b1;
    addressDataIn      = 32'h6000_0000;
    tick();
    idle_inputs();
    chk_quiet("miss_rd_t1");
    tick();
    chk_quiet("miss_rd_t2");
    tick();
    chk_quiet("miss_rd_t3");
    beginTransactionIn = 1'b1;
    addressDataIn      = 32'h6000_0000;
    byteEnablesIn      = 4'hF;
    tick();
    idle_inputs();
    dataValidIn      = 1'b1;
    endTransactionIn = 1'b1;
    addressDataIn    = 32'h7777_7777;
    tick();
    idle_inputs();
    chk_quiet("miss_wr");
    rexp[0] = 32'd0;
    do_read(32'h5000_0000, 0, "miss_nowrite");

    // Write overrun: burst 1 with 3 beats
    wdat[0] = 32'h1234_5678;
    do_write(32'h5000_0048, 4'hF, 8'd0, 1);
    wdat[0] = 32'hA000_000A;
    wdat[1] = 32'hB000_000B;
    wdat[2] = 32'hC000_000C;
    do_write(32'h5000_0040, 4'hF, 8'd1, 3);
    chk("overrun_err", {31'b0, busErrorOut}, 32'd1);
    tick();
    chk("overrun_err_drop", {31'b0, busErrorOut}, 32'd0);
    rexp[0] = 32'hA000_000A;
    rexp[1] = 32'hB000_000B;
    rexp[2] = 32'h1234_5678;
    do_read(32'h5000_0040, 2, "overrun");

    // Reset in the middle of an 8-beat read
    beginTransactionIn = 1'b1;
    readNotWriteIn     = 1'b1;
    addressDataIn      = 32'h5000_0000;
    burstSizeIn        = 8'd7;
    tick();
    idle_inputs();
    tick();
    chk("abort_beat0", addressDataOut, 32'd0);
    chk("abort_dv0",   {31'b0, dataValidOut}, 32'd1);
    tick();
    chk("abort_beat1", addressDataOut, 32'd1);
    reset = 1'b1;
    tick();
    chk_quiet("abort_reset");
    reset = 1'b0;
    tick();
    chk_quiet("abort_after");
    rexp[0] = 32'd0;
    do_read(32'h5000_0000, 0, "abort_recover");

`ifdef BUS_SRAM_SLAVE_BUSY_EN
    begin
      logic [3:0] bs;
      int         idx;
      int         cyc;
      wdat[0] = 32'h5555_5555;
      do_write(32'h5000_0090, 4'hF, 8'd0, 1);
      for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
      beginTransactionIn = 1'b1;
      readNotWriteIn     = 1'b0;
      addressDataIn      = 32'h5000_0080;
      byteEnablesIn      = 4'hF;
      burstSizeIn        = 8'd3;
      tick();
      idle_inputs();
      bs  = 4'b0;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 16) begin
        if (cyc < 4) bs[cyc] = busyOut;
        dataValidIn      = 1'b1;
        addressDataIn    = wdat[idx];
        endTransactionIn = (idx == 3) && !busyOut;
        if (!busyOut) idx++;
        tick();
        cyc++;
      end
      idle_inputs();
      chk("busy_seq",    {28'b0, bs}, 32'b1010);
      chk("busy_cycles", 32'(cyc),    32'd7);
      tick();
      for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + 32'(i);
      rexp[4] = 32'h5555_5555;
      do_read(32'h5000_0080, 4, "busy_rb");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
